// File: rtl/arm_pkg.sv
// Shared definitions for the 5-stage ARM core pipeline.
//   CTRL_W           width of the packed control bundle {mem_read, mem_write, wb_en, b, s}
//   CTRL_*           bit positions inside the control bundle
//   STATUS_*         bit positions of the {N,Z,C,V} status flags
//   EXE_CMD_NOP      ALU command that performs no operation
package arm_pkg;

  localparam int unsigned CTRL_W = 5;

  localparam int unsigned CTRL_MEM_READ  = 4;
  localparam int unsigned CTRL_MEM_WRITE = 3;
  localparam int unsigned CTRL_WB_EN     = 2;
  localparam int unsigned CTRL_B         = 1;
  localparam int unsigned CTRL_S         = 0;

  localparam int unsigned STATUS_N = 3;
  localparam int unsigned STATUS_Z = 2;
  localparam int unsigned STATUS_C = 1;
  localparam int unsigned STATUS_V = 0;

  localparam logic [3:0] EXE_CMD_NOP = 4'd0;

endpackage

// File: rtl/stage_id_to_exe_register_sat_counter.sv
// Saturating event counter.
//   clk    core clock, rising edge
//   clr    synchronous clear (highest priority)
//   inc    count one event this edge
//   count  current value; sticks at all-ones once reached
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stage_id_to_exe_register.sv
// ID -> EXE pipeline register with freeze, flush and bubble insertion.
// Update priority on each rising edge: rst > flush > freeze > bubble > load.
// Ports:
//   clk, rst (sync, active-high), freeze, flush, bubble
//   *_in / *_out   ID-stage fields and their registered copies
//   valid_out      slot holds a live instruction
//   carry_out      registered C flag (status_out[1])
// Optional macro STAGE_ID_EXE_PERF_CNT_EN adds bubble_cnt / flush_cnt (16-bit, saturating).
module stage_id_to_exe_register
  import arm_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  bubble,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     reg1_in,
  input  logic [DATA_W-1:0]     reg2_in,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic [3:0]            exe_cmd_in,
  input  logic                  imm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           imm24_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic [3:0]            status_in,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     reg1_out,
  output logic [DATA_W-1:0]     reg2_out,
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic [3:0]            exe_cmd_out,
  output logic                  imm_out,
  output logic [11:0]           shift_operand_out,
  output logic [23:0]           imm24_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out,
  output logic [3:0]            status_out,
  output logic                  valid_out,
`ifdef STAGE_ID_EXE_PERF_CNT_EN
  output logic [15:0]           bubble_cnt,
  output logic [15:0]           flush_cnt,
`endif
  output logic                  carry_out
);

  logic [DATA_W-1:0]     pc_q, reg1_q, reg2_q;
  logic [CTRL_W-1:0]     ctrl_q;
  logic [3:0]            exe_cmd_q;
  logic                  imm_q;
  logic [11:0]           shift_operand_q;
  logic [23:0]           imm24_q;
  logic [REG_ADDR_W-1:0] rd_q, src1_q, src2_q;
  logic [3:0]            status_q;
  logic                  valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= '0;
      reg1_q          <= '0;
      reg2_q          <= '0;
      ctrl_q          <= '0;
      exe_cmd_q       <= EXE_CMD_NOP;
      imm_q           <= 1'b0;
      shift_operand_q <= '0;
      imm24_q         <= '0;
      rd_q            <= '0;
      src1_q          <= '0;
      src2_q          <= '0;
      status_q        <= '0;
      valid_q         <= 1'b0;
    end else if (flush || !freeze) begin
      // Datapath fields always load; only control and identity fields are killed.
      pc_q            <= pc_in;
      reg1_q          <= reg1_in;
      reg2_q          <= reg2_in;
      shift_operand_q <= shift_operand_in;
      imm24_q         <= imm24_in;
      status_q        <= status_in;
      if (flush) begin
        ctrl_q    <= '0;
        exe_cmd_q <= EXE_CMD_NOP;
        imm_q     <= 1'b0;
        valid_q   <= 1'b0;
        rd_q      <= rd_in;
        src1_q    <= src1_in;
        src2_q    <= src2_in;
      end else if (bubble) begin
        // Register numbers zeroed so forwarding can never match a bubble.
        ctrl_q    <= '0;
        exe_cmd_q <= EXE_CMD_NOP;
        imm_q     <= 1'b0;
        valid_q   <= 1'b0;
        rd_q      <= '0;
        src1_q    <= '0;
        src2_q    <= '0;
      end else begin
        ctrl_q    <= ctrl_in;
        exe_cmd_q <= exe_cmd_in;
        imm_q     <= imm_in;
        valid_q   <= 1'b1;
        rd_q      <= rd_in;
        src1_q    <= src1_in;
        src2_q    <= src2_in;
      end
    end
  end

  assign pc_out            = pc_q;
  assign reg1_out          = reg1_q;
  assign reg2_out          = reg2_q;
  assign ctrl_out          = ctrl_q;
  assign exe_cmd_out       = exe_cmd_q;
  assign imm_out           = imm_q;
  assign shift_operand_out = shift_operand_q;
  assign imm24_out         = imm24_q;
  assign rd_out            = rd_q;
  assign src1_out          = src1_q;
  assign src2_out          = src2_q;
  assign status_out        = status_q;
  assign valid_out         = valid_q;
  assign carry_out         = status_q[STATUS_C];

`ifdef STAGE_ID_EXE_PERF_CNT_EN
  logic bubble_taken, flush_taken;

  // A bubble only counts when it actually wins priority over flush and freeze.
  assign flush_taken  = flush;
  assign bubble_taken = bubble && !flush && !freeze;

  sat_counter #(
    .WIDTH (16)
  ) u_bubble_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (bubble_taken),
    .count (bubble_cnt)
  );

  sat_counter #(
    .WIDTH (16)
  ) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (flush_taken),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_stage_id_to_exe_register.sv
// Directed bench for stage_id_to_exe_register.
module tb_stage_id_to_exe_register;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, bubble;
  logic [31:0] pc_in, reg1_in, reg2_in;
  logic [4:0]  ctrl_in;
  logic [3:0]  exe_cmd_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] imm24_in;
  logic [3:0]  rd_in, src1_in, src2_in, status_in;

  logic [31:0] pc_out, reg1_out, reg2_out;
  logic [4:0]  ctrl_out;
  logic [3:0]  exe_cmd_out;
  logic        imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] imm24_out;
  logic [3:0]  rd_out, src1_out, src2_out, status_out;
  logic        valid_out, carry_out;
`ifdef STAGE_ID_EXE_PERF_CNT_EN
  logic [15:0] bubble_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_id_to_exe_register dut (
    .clk               (clk),
    .rst               (rst),
    .freeze            (freeze),
    .flush             (flush),
    .bubble            (bubble),
    .pc_in             (pc_in),
    .reg1_in           (reg1_in),
    .reg2_in           (reg2_in),
    .ctrl_in           (ctrl_in),
    .exe_cmd_in        (exe_cmd_in),
    .imm_in            (imm_in),
    .shift_operand_in  (shift_operand_in),
    .imm24_in          (imm24_in),
    .rd_in             (rd_in),
    .src1_in           (src1_in),
    .src2_in           (src2_in),
    .status_in         (status_in),
    .pc_out            (pc_out),
    .reg1_out          (reg1_out),
    .reg2_out          (reg2_out),
    .ctrl_out          (ctrl_out),
    .exe_cmd_out       (exe_cmd_out),
    .imm_out           (imm_out),
    .shift_operand_out (shift_operand_out),
    .imm24_out         (imm24_out),
    .rd_out            (rd_out),
    .src1_out          (src1_out),
    .src2_out          (src2_out),
    .status_out        (status_out),
    .valid_out         (valid_out),
`ifdef STAGE_ID_EXE_PERF_CNT_EN
    .bubble_cnt        (bubble_cnt),
    .flush_cnt         (flush_cnt),
`endif
    .carry_out         (carry_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; bubble = 1'b0;
    pc_in = $urandom; reg1_in = $urandom; reg2_in = $urandom;
    ctrl_in = 5'($urandom); exe_cmd_in = 4'($urandom); imm_in = 1'b1;
    shift_operand_in = 12'($urandom); imm24_in = 24'($urandom);
    rd_in = 4'($urandom); src1_in = 4'($urandom); src2_in = 4'($urandom);
    status_in = 4'hF;
    tick();
    check("rst_pc", pc_out, 0);
    check("rst_reg1", reg1_out, 0);
    check("rst_reg2", reg2_out, 0);
    check("rst_ctrl", 32'(ctrl_out), 0);
    check("rst_exe", 32'(exe_cmd_out), 0);
    check("rst_imm", 32'(imm_out), 0);
    check("rst_shift", 32'(shift_operand_out), 0);
    check("rst_imm24", 32'(imm24_out), 0);
    check("rst_rd", 32'(rd_out), 0);
    check("rst_src1", 32'(src1_out), 0);
    check("rst_src2", 32'(src2_out), 0);
    check("rst_status", 32'(status_out), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_carry", 32'(carry_out), 0);

    // Plain load
    rst = 1'b0;
    pc_in = 32'h8; reg1_in = 32'h5; reg2_in = 32'hAA; ctrl_in = 5'b00101;
    exe_cmd_in = 4'h4; imm_in = 1'b1; shift_operand_in = 12'h123; imm24_in = 24'hABCDEF;
    rd_in = 4'd3; src1_in = 4'd1; src2_in = 4'd2; status_in = 4'b0010;
    tick();
    check("ld_pc", pc_out, 32'h8);
    check("ld_reg1", reg1_out, 32'h5);
    check("ld_reg2", reg2_out, 32'hAA);
    check("ld_ctrl", 32'(ctrl_out), 32'b00101);
    check("ld_exe", 32'(exe_cmd_out), 4);
    check("ld_imm", 32'(imm_out), 1);
    check("ld_shift", 32'(shift_operand_out), 32'h123);
    check("ld_imm24", 32'(imm24_out), 32'hABCDEF);
    check("ld_rd", 32'(rd_out), 3);
    check("ld_src1", 32'(src1_out), 1);
    check("ld_src2", 32'(src2_out), 2);
    check("ld_status", 32'(status_out), 32'b0010);
    check("ld_valid", 32'(valid_out), 1);
    check("ld_carry", 32'(carry_out), 1);

    // Freeze holds everything
    pc_in = 32'h10; status_in = 4'b0000;
    tick();
    check("fz_pre_pc", pc_out, 32'h10);
    check("fz_pre_carry", 32'(carry_out), 0);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'h100 + 32'(i); ctrl_in = 5'b11000; status_in = 4'b0010; rd_in = 4'd9;
      tick();
      check("fz_pc", pc_out, 32'h10);
      check("fz_valid", 32'(valid_out), 1);
      check("fz_ctrl", 32'(ctrl_out), 32'b00101);
      check("fz_carry", 32'(carry_out), 0);
    end

    // Flush beats freeze
    flush = 1'b1; ctrl_in = 5'b11111; exe_cmd_in = 4'hF; imm_in = 1'b1; pc_in = 32'h20;
    tick();
    check("fl_ctrl", 32'(ctrl_out), 0);
    check("fl_exe", 32'(exe_cmd_out), 0);
    check("fl_imm", 32'(imm_out), 0);
    check("fl_valid", 32'(valid_out), 0);

    // Bubble
    flush = 1'b0; freeze = 1'b0; bubble = 1'b1;
    src1_in = 4'd7; src2_in = 4'd5; rd_in = 4'd9; ctrl_in = 5'b00100; exe_cmd_in = 4'd3;
    imm_in = 1'b1; pc_in = 32'h30; reg1_in = 32'h77;
    tick();
    check("bb_src1", 32'(src1_out), 0);
    check("bb_src2", 32'(src2_out), 0);
    check("bb_rd", 32'(rd_out), 0);
    check("bb_ctrl", 32'(ctrl_out), 0);
    check("bb_exe", 32'(exe_cmd_out), 0);
    check("bb_imm", 32'(imm_out), 0);
    check("bb_valid", 32'(valid_out), 0);
    check("bb_pc", pc_out, 32'h30);
    check("bb_reg1", reg1_out, 32'h77);

    // Normal load after bubble
    bubble = 1'b0; ctrl_in = 5'b01010; rd_in = 4'd6; pc_in = 32'h34;
    tick();
    check("rl_valid", 32'(valid_out), 1);
    check("rl_ctrl", 32'(ctrl_out), 32'b01010);
    check("rl_rd", 32'(rd_out), 6);
    check("rl_src1", 32'(src1_out), 7);

    // Freeze outranks bubble
    freeze = 1'b1; bubble = 1'b1; pc_in = 32'h38;
    tick();
    check("fb_valid", 32'(valid_out), 1);
    check("fb_ctrl", 32'(ctrl_out), 32'b01010);
    check("fb_pc", pc_out, 32'h34);

    // Reset mid-stall
    rst = 1'b1; bubble = 1'b0;
    tick();
    check("rs_valid", 32'(valid_out), 0);
    check("rs_pc", pc_out, 0);
    check("rs_ctrl", 32'(ctrl_out), 0);
    rst = 1'b0; freeze = 1'b0;

`ifdef STAGE_ID_EXE_PERF_CNT_EN
    check("pc_rst_b", 32'(bubble_cnt), 0);
    check("pc_rst_f", 32'(flush_cnt), 0);
    bubble = 1'b1;
    repeat (3) tick();
    bubble = 1'b0; flush = 1'b1;
    repeat (2) tick();
    flush = 1'b0; freeze = 1'b1; bubble = 1'b1;
    tick();
    check("pc_b3", 32'(bubble_cnt), 3);
    check("pc_f2", 32'(flush_cnt), 2);
    freeze = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    check("pc_bsat", 32'(bubble_cnt), 32'hFFFF);
    check("pc_fkeep", 32'(flush_cnt), 2);
    bubble = 1'b0; rst = 1'b1;
    tick();
    check("pc_clr_b", 32'(bubble_cnt), 0);
    check("pc_clr_f", 32'(flush_cnt), 0);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
